// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load-flag encodings and the EX->MEM bus layout
// for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned STALL_WD           = 6;
  localparam int unsigned EX_TO_MEM_WD       = 76;
  localparam int unsigned MEM_TO_WB_WD       = 70;
  localparam int unsigned MEM_TO_ID_WD       = 38;
  localparam int unsigned LOAD_SRAM_DATA_WD  = 5;
  localparam int unsigned STORE_SRAM_DATA_WD = 3;

  typedef enum logic {
    NO_STOP = 1'b0,
    STOP    = 1'b1
  } stall_e;

  // Load flag order on the bus is {lb, lh, lw, lbu, lhu}.
  localparam logic [LOAD_SRAM_DATA_WD-1:0] LD_LB  = 5'b10000;
  localparam logic [LOAD_SRAM_DATA_WD-1:0] LD_LH  = 5'b01000;
  localparam logic [LOAD_SRAM_DATA_WD-1:0] LD_LW  = 5'b00100;
  localparam logic [LOAD_SRAM_DATA_WD-1:0] LD_LBU = 5'b00010;
  localparam logic [LOAD_SRAM_DATA_WD-1:0] LD_LHU = 5'b00001;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/halfword/word from the SRAM read word and extends it.
// Purely combinational.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LOAD_SRAM_DATA_WD-1:0] flags,
  input  logic [1:0]                   off,
  input  logic [31:0]                  word,
  output logic [31:0]                  value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    unique case (off)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];

    value = '0;
    case (flags)
      LD_LB:   value = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  value = {24'd0, byte_v};
      LD_LH:   value = {{16{half_v[15]}}, half_v};
      LD_LHU:  value = {16'd0, half_v};
      LD_LW:   value = word;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus under the stall vector, aligns load
// data from the synchronous data SRAM, and drives the MEM->WB and MEM->ID buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [STALL_WD-1:0]           stall,
  input  logic [EX_TO_MEM_WD-1:0]       ex_to_mem_bus,
  input  logic [LOAD_SRAM_DATA_WD-1:0]  load_sram_ex_data,
  input  logic [STORE_SRAM_DATA_WD-1:0] store_sram_ex_data,
  input  logic [31:0]                   data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0]       mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0]       mem_to_id_bus,
  output logic [LOAD_SRAM_DATA_WD-1:0]  load_sram_wb_data,
  output logic [STORE_SRAM_DATA_WD-1:0] store_sram_wb_data
);

  ex_to_mem_t                    ex_q, ex_d;
  logic [LOAD_SRAM_DATA_WD-1:0]  load_q, load_d;
  logic [STORE_SRAM_DATA_WD-1:0] store_q, store_d;
  logic                          first_cycle_q, first_cycle_d;
  logic [31:0]                   rdata_buf_q, rdata_buf_d;

  logic [31:0] rdata_eff;
  logic [31:0] load_value;
  logic [31:0] rf_wdata;

  always_comb begin
    ex_d          = ex_q;
    load_d        = load_q;
    store_d       = store_q;
    first_cycle_d = 1'b0;
    // The SRAM word is only valid in the first cycle of an entry; keep it for held cycles.
    rdata_buf_d   = first_cycle_q ? data_sram_rdata : rdata_buf_q;

    if (rst) begin
      ex_d        = '0;
      load_d      = '0;
      store_d     = '0;
      rdata_buf_d = '0;
    end else if (stall[3] == STOP && stall[4] == NO_STOP) begin
      ex_d    = '0;
      load_d  = '0;
      store_d = '0;
    end else if (stall[3] == NO_STOP) begin
      ex_d          = ex_to_mem_t'(ex_to_mem_bus);
      load_d        = load_sram_ex_data;
      store_d       = store_sram_ex_data;
      first_cycle_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    ex_q          <= ex_d;
    load_q        <= load_d;
    store_q       <= store_d;
    first_cycle_q <= first_cycle_d;
    rdata_buf_q   <= rdata_buf_d;
  end

  assign rdata_eff = first_cycle_q ? data_sram_rdata : rdata_buf_q;

  load_align u_load_align (
    .flags (load_q),
    .off   (ex_q.ex_result[1:0]),
    .word  (rdata_eff),
    .value (load_value)
  );

  assign rf_wdata           = ex_q.sel_rf_res ? load_value : ex_q.ex_result;
  assign mem_to_wb_bus      = {ex_q.pc, ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
  assign mem_to_id_bus      = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
  assign load_sram_wb_data  = load_q;
  assign store_sram_wb_data = store_q;

  // SRAM enables and the other stall bits are consumed elsewhere in the pipeline.
  logic unused_bits;
  assign unused_bits = ^{ex_q.data_ram_en, ex_q.data_ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: table of single-cycle load/ALU vectors
// plus hand-written hold, bubble and reset-during-hold sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  load_sram_ex_data;
  logic [2:0]  store_sram_ex_data;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;
  logic [4:0]  load_sram_wb_data;
  logic [2:0]  store_sram_wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] LB = 5'b10000, LH = 5'b01000, LW = 5'b00100,
                         LBU = 5'b00010, LHU = 5'b00001, NOLD = 5'b00000;

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .ex_to_mem_bus      (ex_to_mem_bus),
    .load_sram_ex_data  (load_sram_ex_data),
    .store_sram_ex_data (store_sram_ex_data),
    .data_sram_rdata    (data_sram_rdata),
    .mem_to_wb_bus      (mem_to_wb_bus),
    .mem_to_id_bus      (mem_to_id_bus),
    .load_sram_wb_data  (load_sram_wb_data),
    .store_sram_wb_data (store_sram_wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] exres;
    logic [4:0]  ld;
    logic [2:0]  st;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic sel, input logic we,
                          input logic [4:0] waddr, input logic [31:0] exres,
                          input logic [4:0] ld, input logic [2:0] st);
    ex_to_mem_bus      = {pc, 1'b1, 4'b0000, sel, we, waddr, exres};
    load_sram_ex_data  = ld;
    store_sram_ex_data = st;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wdata(input string name, input logic [31:0] pc, input logic we,
                             input logic [4:0] waddr, input logic [31:0] wdata);
    check({name, "_wb"}, mem_to_wb_bus, {pc, we, waddr, wdata});
    check({name, "_id"}, 70'(mem_to_id_bus), 70'({we, waddr, wdata}));
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1000, 1'b1, 1'b1, 5'd5,  32'h0000_0100, LW,   3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_1004, 1'b1, 1'b1, 5'd6,  32'h0000_0103, LB,   3'b000, 32'h8012_3456, 32'hFFFF_FF80};
    vecs[2]  = '{32'h0000_1008, 1'b1, 1'b1, 5'd7,  32'h0000_0103, LBU,  3'b000, 32'h8012_3456, 32'h0000_0080};
    vecs[3]  = '{32'h0000_100C, 1'b1, 1'b1, 5'd8,  32'h0000_0102, LH,   3'b000, 32'h8012_3456, 32'hFFFF_8012};
    vecs[4]  = '{32'h0000_1010, 1'b1, 1'b1, 5'd9,  32'h0000_0100, LHU,  3'b000, 32'h8001_1234, 32'h0000_1234};
    vecs[5]  = '{32'h0000_1014, 1'b1, 1'b1, 5'd10, 32'h0000_0101, LB,   3'b000, 32'h8012_3456, 32'h0000_0034};
    vecs[6]  = '{32'h0000_1018, 1'b1, 1'b0, 5'd11, 32'h0000_0200, LBU,  3'b000, 32'h0000_00F0, 32'h0000_00F0};
    vecs[7]  = '{32'h0000_101C, 1'b1, 1'b1, 5'd12, 32'h0000_0203, LH,   3'b000, 32'h7FFF_0000, 32'h0000_7FFF};
    vecs[8]  = '{32'h0000_1020, 1'b0, 1'b1, 5'd13, 32'h1234_5678, NOLD, 3'b100, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[9]  = '{32'h0000_1024, 1'b1, 1'b1, 5'd14, 32'h0000_0300, NOLD, 3'b001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{32'h0000_1028, 1'b1, 1'b1, 5'd31, 32'h0000_0402, LW,   3'b000, 32'h1357_2468, 32'h1357_2468};

    rst   = 1'b1;
    stall = '0;
    data_sram_rdata = 32'h5A5A_5A5A;
    drive_ex(32'hFFFF_FFFF, 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, LW, 3'b111);
    tick();
    tick();
    check("reset_wb", mem_to_wb_bus, '0);
    check("reset_id", 70'(mem_to_id_bus), '0);
    check("reset_flags", 70'({load_sram_wb_data, store_sram_wb_data}), '0);
    rst = 1'b0;

    // Back-to-back entries with no stall: each result appears the cycle after issue.
    for (int i = 0; i < 11; i++) begin
      drive_ex(vecs[i].pc, vecs[i].sel, vecs[i].we, vecs[i].waddr, vecs[i].exres,
               vecs[i].ld, vecs[i].st);
      tick();
      data_sram_rdata = vecs[i].rdata;
      #1;
      check_wdata($sformatf("vec%0d", i), vecs[i].pc, vecs[i].we, vecs[i].waddr, vecs[i].exp);
      check($sformatf("vec%0d_flags", i), 70'({load_sram_wb_data, store_sram_wb_data}),
            70'({vecs[i].ld, vecs[i].st}));
    end

    // ALU result ignores the SRAM word even when it toggles.
    data_sram_rdata = 32'h0F0F_0F0F;
    drive_ex(32'h0000_2000, 1'b0, 1'b1, 5'd2, 32'h1234_5678, NOLD, 3'b000);
    tick();
    data_sram_rdata = 32'hF0F0_F0F0;
    #1;
    check_wdata("alu_t0", 32'h0000_2000, 1'b1, 5'd2, 32'h1234_5678);
    data_sram_rdata = 32'h0F0F_0F0F;
    #1;
    check_wdata("alu_t1", 32'h0000_2000, 1'b1, 5'd2, 32'h1234_5678);

    // Load held for three cycles while the SRAM word changes underneath.
    drive_ex(32'h0000_3000, 1'b1, 1'b1, 5'd20, 32'h0000_0500, LW, 3'b000);
    tick();
    data_sram_rdata = 32'hAAAA_5555;
    #1;
    check_wdata("hold_c0", 32'h0000_3000, 1'b1, 5'd20, 32'hAAAA_5555);
    stall = 6'b011111;
    drive_ex(32'h0000_3004, 1'b0, 1'b0, 5'd1, 32'h9999_9999, LB, 3'b010);
    for (int c = 1; c <= 3; c++) begin
      tick();
      data_sram_rdata = 32'h1111_1111;
      #1;
      check_wdata($sformatf("hold_c%0d", c), 32'h0000_3000, 1'b1, 5'd20, 32'hAAAA_5555);
    end

    // Bubble: input side stopped, own stage free.
    stall = 6'b001111;
    tick();
    check("bubble_wb", mem_to_wb_bus, '0);
    check("bubble_id", 70'(mem_to_id_bus), '0);
    check("bubble_flags", 70'({load_sram_wb_data, store_sram_wb_data}), '0);
    stall = '0;
    drive_ex(32'h0000_4000, 1'b1, 1'b1, 5'd7, 32'h0000_0600, LHU, 3'b000);
    tick();
    data_sram_rdata = 32'h7777_BEEF;
    #1;
    check_wdata("after_bubble", 32'h0000_4000, 1'b1, 5'd7, 32'h0000_BEEF);

    // Reset arriving in the second held cycle of a load.
    drive_ex(32'h0000_5000, 1'b1, 1'b1, 5'd9, 32'h0000_0700, LW, 3'b000);
    tick();
    data_sram_rdata = 32'h1234_5678;
    #1;
    check_wdata("rsthold_c0", 32'h0000_5000, 1'b1, 5'd9, 32'h1234_5678);
    stall = 6'b011111;
    tick();
    data_sram_rdata = 32'hBBBB_BBBB;
    #1;
    check_wdata("rsthold_c1", 32'h0000_5000, 1'b1, 5'd9, 32'h1234_5678);
    tick();
    rst = 1'b1;
    tick();
    check("rsthold_wb", mem_to_wb_bus, '0);
    check("rsthold_id", 70'(mem_to_id_bus), '0);
    rst   = 1'b0;
    stall = '0;
    drive_ex(32'h0000_6000, 1'b1, 1'b1, 5'd4, 32'h0000_0800, LW, 3'b000);
    tick();
    data_sram_rdata = 32'h0000_CAFE;
    #1;
    check_wdata("after_rst", 32'h0000_6000, 1'b1, 5'd4, 32'h0000_CAFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
